// File: rtl/tff_mod_counter_pkg.sv
// Shared constants and elaboration helpers for the T-type modulo-N counter.
package tff_mod_counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // MODULUS must need no more than WIDTH bits to represent its full range.
  function automatic bit modulus_in_range(input int width, input int modulus);
    return (modulus >= 2) && ($clog2(modulus) <= width);
  endfunction

endpackage

// File: rtl/tff_toggle_gen.sv
// Combinational toggle-mask generator: derives each bit's T input and the
// terminal-count flag from the current count and the control inputs.
module tff_toggle_gen
  import tff_mod_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic [WIDTH-1:0] Q,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] t_vec,
  output logic             tc
);

  localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] MOD_MAX = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);

  logic [WIDTH:0] q_ext;
  logic [WIDTH:0] lv_ext;
  logic [WIDTH:0] next_ext;
  logic [WIDTH:0] t_ext;
  logic           carry_unused;

  assign q_ext  = {1'b0, Q};
  assign lv_ext = {1'b0, load_val};

  // The >= compare also steers an out-of-range count back to zero on an up step.
  always_comb begin
    next_ext = q_ext;
    if (load) begin
      next_ext = (lv_ext < MOD_EXT) ? lv_ext : MOD_MAX;
    end else if (en) begin
      if (up_dn == DIR_UP) begin
        next_ext = (q_ext >= MOD_MAX) ? '0 : q_ext + ONE_EXT;
      end else if (up_dn == DIR_DN) begin
        next_ext = (q_ext == '0) ? MOD_MAX : q_ext - ONE_EXT;
      end
    end
  end

  assign t_ext        = q_ext ^ next_ext;
  assign t_vec        = t_ext[WIDTH-1:0];
  assign carry_unused = t_ext[WIDTH];

  assign tc = en & ((up_dn == DIR_UP) ? (q_ext == MOD_MAX) : (q_ext == '0));

endmodule

// File: rtl/tff_mod_counter.sv
// Modulo-N up/down counter built as a bank of T flip-flops driven by an
// exposed toggle mask, with a registered wrap pulse.
module tff_mod_counter
  import tff_mod_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QBar,
  output logic [WIDTH-1:0] t_vec,
  output logic             tc,
  output logic             wrap
);

  if (!modulus_in_range(WIDTH, MODULUS)) begin : g_bad_modulus
    $error("tff_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  tff_toggle_gen #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_toggle (
    .Q        (Q),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .t_vec    (t_vec),
    .tc       (tc)
  );

  // T-type update: every non-reset change to the count goes through t_vec.
  always_ff @(posedge clk) begin
    if (!reset) begin
      Q    <= '0;
      wrap <= 1'b0;
    end else begin
      Q    <= Q ^ t_vec;
      wrap <= tc & ~load;
    end
  end

  assign QBar = ~Q;

endmodule
